multicycle_controller: RTL and testbench

- Sequencing control FSM for the multicycle RV32I-subset datapath: one shared memory for instructions and data, plus IR, OldPC, Data and ALUOut registers.
- Issues per-state enables and mux selects for the datapath, and decodes ImmSrc and ALUControl from the instruction register.
- Supports lw, sw, R-type, I-type ALU, beq and jal.
- Handles a memory ready handshake, so memory accesses may stall.

---
 rtl/mc_pkg.sv | 58 +++++
 rtl/multicycle_controller_alu_dec.sv | 36 +++
 rtl/multicycle_controller.sv | 176 +++++++++++++++++
 tb/tb_multicycle_controller.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle RV32I-subset controller.
// Imported by the FSM top and the ALU decoder.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] ALUC_ADD = 3'b000;
    localparam logic [2:0] ALUC_SUB = 3'b001;
    localparam logic [2:0] ALUC_AND = 3'b010;
    localparam logic [2:0] ALUC_OR  = 3'b011;
    localparam logic [2:0] ALUC_SLT = 3'b101;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_WD   = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    function automatic logic op_supported(input logic [6:0] op);
        return (op == OP_LW) || (op == OP_SW) || (op == OP_R) ||
               (op == OP_I) || (op == OP_JAL) || (op == OP_BEQ);
    endfunction

endpackage

// File: rtl/multicycle_controller_alu_dec.sv
// ALU decoder: maps ALUOp plus instruction function fields to ALUControl.
// Pure combinational; subtraction only for R-type with funct7b5 set.
import mc_pkg::*;

module mc_alu_dec (
    input  logic [1:0] i_alu_op,
    input  logic [2:0] i_funct3,
    input  logic       i_op5,
    input  logic       i_funct7b5,
    output logic [2:0] o_alu_control
);

    logic w_rtype_sub;

    assign w_rtype_sub = i_op5 & i_funct7b5;

    always_comb begin
        o_alu_control = ALUC_ADD;
        case (i_alu_op)
            ALUOP_ADD: o_alu_control = ALUC_ADD;
            ALUOP_SUB: o_alu_control = ALUC_SUB;
            ALUOP_FUNCT: begin
                case (i_funct3)
                    3'b000:  o_alu_control = w_rtype_sub ? ALUC_SUB
                                                         : ALUC_ADD;
                    3'b010:  o_alu_control = ALUC_SLT;
                    3'b110:  o_alu_control = ALUC_OR;
                    3'b111:  o_alu_control = ALUC_AND;
                    default: o_alu_control = ALUC_ADD;
                endcase
            end
            default: o_alu_control = ALUC_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Sequencing FSM for the multicycle RV32I-subset datapath with a
// stallable shared memory (mem_ready handshake).
import mc_pkg::*;

module multicycle_controller #(
    parameter state_t RESET_STATE = S_FETCH
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       RegWrite,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       instr_done,
    output logic       illegal_instr
);

    state_t     r_state;

    logic       w_pc_update;
    logic       w_branch;
    logic       w_ir_write;
    logic       w_mem_write;
    logic       w_reg_write;
    logic       w_done;
    logic       w_illegal;
    logic       w_adr_src;
    logic [1:0] w_result_src;
    logic [1:0] w_src_a;
    logic [1:0] w_src_b;
    logic [1:0] w_alu_op;
    logic [1:0] w_imm_src;
    logic       w_op_ok;

    assign w_op_ok = op_supported(op);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= RESET_STATE;
        end else begin
            case (r_state)
                S_FETCH:    if (mem_ready) r_state <= S_DECODE;
                S_DECODE: begin
                    if (op == OP_LW || op == OP_SW) r_state <= S_MEMADR;
                    else if (op == OP_R)            r_state <= S_EXECR;
                    else if (op == OP_I)            r_state <= S_EXECI;
                    else if (op == OP_JAL)          r_state <= S_JAL;
                    else if (op == OP_BEQ)          r_state <= S_BEQ;
                    else                            r_state <= S_FETCH;
                end
                S_MEMADR:   r_state <= op[5] ? S_MEMWRITE : S_MEMREAD;
                S_MEMREAD:  if (mem_ready) r_state <= S_MEMWB;
                S_MEMWB:    r_state <= S_FETCH;
                S_MEMWRITE: if (mem_ready) r_state <= S_FETCH;
                S_EXECR:    r_state <= S_ALUWB;
                S_EXECI:    r_state <= S_ALUWB;
                S_ALUWB:    r_state <= S_FETCH;
                S_JAL:      r_state <= S_ALUWB;
                S_BEQ:      r_state <= S_FETCH;
                default:    r_state <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        w_pc_update  = 1'b0;
        w_branch     = 1'b0;
        w_ir_write   = 1'b0;
        w_mem_write  = 1'b0;
        w_reg_write  = 1'b0;
        w_done       = 1'b0;
        w_illegal    = 1'b0;
        w_adr_src    = 1'b0;
        w_result_src = RES_ALUOUT;
        w_src_a      = SRCA_PC;
        w_src_b      = SRCB_WD;
        w_alu_op     = ALUOP_ADD;
        case (r_state)
            S_FETCH: begin
                w_src_b      = SRCB_FOUR;
                w_result_src = RES_ALURES;
                w_ir_write   = mem_ready;
                w_pc_update  = mem_ready;
            end
            S_DECODE: begin
                w_src_a   = SRCA_OLDPC;
                w_src_b   = SRCB_IMM;
                w_illegal = ~w_op_ok;
                w_done    = ~w_op_ok;
            end
            S_MEMADR: begin
                w_src_a = SRCA_RD1;
                w_src_b = SRCB_IMM;
            end
            S_MEMREAD: w_adr_src = 1'b1;
            S_MEMWB: begin
                w_result_src = RES_DATA;
                w_reg_write  = 1'b1;
                w_done       = 1'b1;
            end
            S_MEMWRITE: begin
                w_adr_src   = 1'b1;
                w_mem_write = 1'b1;
                w_done      = mem_ready;
            end
            S_EXECR: begin
                w_src_a  = SRCA_RD1;
                w_alu_op = ALUOP_FUNCT;
            end
            S_EXECI: begin
                w_src_a  = SRCA_RD1;
                w_src_b  = SRCB_IMM;
                w_alu_op = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                w_reg_write = 1'b1;
                w_done      = 1'b1;
            end
            S_JAL: begin
                w_src_a     = SRCA_OLDPC;
                w_src_b     = SRCB_FOUR;
                w_pc_update = 1'b1;
            end
            S_BEQ: begin
                w_src_a  = SRCA_RD1;
                w_alu_op = ALUOP_SUB;
                w_branch = 1'b1;
                w_done   = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        unique case (1'b1)
            (op == OP_SW):  w_imm_src = IMM_S;
            (op == OP_BEQ): w_imm_src = IMM_B;
            (op == OP_JAL): w_imm_src = IMM_J;
            default:        w_imm_src = IMM_I;
        endcase
    end

    mc_alu_dec u_alu_dec (
        .i_alu_op      (w_alu_op),
        .i_funct3      (funct3),
        .i_op5         (op[5]),
        .i_funct7b5    (funct7b5),
        .o_alu_control (ALUControl)
    );

    // Write enables and pulses are squashed while reset is held so an
    // abandoned instruction never commits state.
    assign PCWrite       = ~reset & ((w_branch & zero) | w_pc_update);
    assign IRWrite       = ~reset & w_ir_write;
    assign MemWrite      = ~reset & w_mem_write;
    assign RegWrite      = ~reset & w_reg_write;
    assign instr_done    = ~reset & w_done;
    assign illegal_instr = ~reset & w_illegal;
    assign AdrSrc        = w_adr_src;
    assign ResultSrc     = w_result_src;
    assign ALUSrcA       = w_src_a;
    assign ALUSrcB       = w_src_b;
    assign ImmSrc        = w_imm_src;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: directed per-cycle vectors
// with hand-written expected outputs checked by a separate monitor.
module tb_multicycle_controller;

    typedef struct packed {
        logic       pcw;
        logic       adr;
        logic       mw;
        logic       irw;
        logic [1:0] res;
        logic [1:0] sa;
        logic [1:0] sb;
        logic       rw;
        logic [1:0] imm;
        logic [2:0] aluc;
        logic       done;
        logic       ill;
    } exp_t;

    typedef struct {
        string name;
        exp_t  e;
    } item_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] op = 7'b0000011;
    logic [2:0] funct3 = 3'b000;
    logic       funct7b5 = 1'b0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b1;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
    logic       instr_done, illegal_instr;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;

    item_t q[$];
    int    n_checks = 0;
    int    n_errors = 0;

    always #5 clk = ~clk;

    multicycle_controller dut (
        .clk           (clk),
        .reset         (reset),
        .op            (op),
        .funct3        (funct3),
        .funct7b5      (funct7b5),
        .zero          (zero),
        .mem_ready     (mem_ready),
        .PCWrite       (PCWrite),
        .AdrSrc        (AdrSrc),
        .MemWrite      (MemWrite),
        .IRWrite       (IRWrite),
        .ResultSrc     (ResultSrc),
        .ALUSrcA       (ALUSrcA),
        .ALUSrcB       (ALUSrcB),
        .RegWrite      (RegWrite),
        .ImmSrc        (ImmSrc),
        .ALUControl    (ALUControl),
        .instr_done    (instr_done),
        .illegal_instr (illegal_instr)
    );

    function automatic exp_t mk(
        input logic pcw, adr, mw, irw,
        input logic [1:0] res, sa, sb,
        input logic rw,
        input logic [1:0] imm,
        input logic [2:0] aluc,
        input logic done, ill
    );
        mk = '{pcw, adr, mw, irw, res, sa, sb, rw, imm, aluc, done, ill};
    endfunction

    // Drive one cycle of inputs and queue the outputs expected in it.
    task automatic cyc(input string nm, input logic rst,
                       input logic [6:0] o, input logic [2:0] f3,
                       input logic f7, input logic z, input logic rdy,
                       input exp_t e);
        item_t it;
        @(posedge clk);
        #1;
        reset = rst; op = o; funct3 = f3; funct7b5 = f7;
        zero = z; mem_ready = rdy;
        it.name = nm;
        it.e = e;
        q.push_back(it);
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            item_t it;
            exp_t  got;
            it = q.pop_front();
            got = '{PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA,
                    ALUSrcB, RegWrite, ImmSrc, ALUControl, instr_done,
                    illegal_instr};
            n_checks++;
            if (got !== it.e) begin
                n_errors++;
                $display("FAIL %s: got %b required %b", it.name, got, it.e);
            end
        end
    end

    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IT  = 7'b0010011;
    localparam logic [6:0] JL  = 7'b1101111;
    localparam logic [6:0] BQ  = 7'b1100011;
    localparam logic [6:0] BAD = 7'b1111111;

    initial begin
        // reset: FETCH selects, enables forced low
        cyc("rst0", 1, LW, 0, 0, 0, 1, mk(0,0,0,0,2,0,2,0,0,0,0,0));
        cyc("rst1", 1, LW, 0, 0, 0, 1, mk(0,0,0,0,2,0,2,0,0,0,0,0));
        // lw, no stalls
        cyc("lw_f",  0, LW, 0, 0, 0, 1, mk(1,0,0,1,2,0,2,0,0,0,0,0));
        cyc("lw_d",  0, LW, 0, 0, 0, 1, mk(0,0,0,0,0,1,1,0,0,0,0,0));
        cyc("lw_ma", 0, LW, 0, 0, 0, 1, mk(0,0,0,0,0,2,1,0,0,0,0,0));
        cyc("lw_mr", 0, LW, 0, 0, 0, 1, mk(0,1,0,0,0,0,0,0,0,0,0,0));
        cyc("lw_wb", 0, LW, 0, 0, 0, 1, mk(0,0,0,0,1,0,0,1,0,0,1,0));
        // sw, two stall cycles in MEMWRITE
        cyc("sw_f",   0, SW, 0, 0, 0, 1, mk(1,0,0,1,2,0,2,0,1,0,0,0));
        cyc("sw_d",   0, SW, 0, 0, 0, 0, mk(0,0,0,0,0,1,1,0,1,0,0,0));
        cyc("sw_ma",  0, SW, 0, 0, 0, 0, mk(0,0,0,0,0,2,1,0,1,0,0,0));
        cyc("sw_mw0", 0, SW, 0, 0, 0, 0, mk(0,1,1,0,0,0,0,0,1,0,0,0));
        cyc("sw_mw1", 0, SW, 0, 0, 0, 0, mk(0,1,1,0,0,0,0,0,1,0,0,0));
        cyc("sw_mw2", 0, SW, 0, 0, 0, 1, mk(0,1,1,0,0,0,0,0,1,0,1,0));
        // R sub with one FETCH stall
        cyc("rs_fs", 0, RT, 0, 1, 0, 0, mk(0,0,0,0,2,0,2,0,0,0,0,0));
        cyc("rs_f",  0, RT, 0, 1, 0, 1, mk(1,0,0,1,2,0,2,0,0,0,0,0));
        cyc("rs_d",  0, RT, 0, 1, 0, 0, mk(0,0,0,0,0,1,1,0,0,0,0,0));
        cyc("rs_ex", 0, RT, 0, 1, 0, 0, mk(0,0,0,0,0,2,0,0,0,1,0,0));
        cyc("rs_wb", 0, RT, 0, 1, 0, 0, mk(0,0,0,0,0,0,0,1,0,0,1,0));
        // R add
        cyc("ra_f",  0, RT, 0, 0, 0, 1, mk(1,0,0,1,2,0,2,0,0,0,0,0));
        cyc("ra_d",  0, RT, 0, 0, 0, 1, mk(0,0,0,0,0,1,1,0,0,0,0,0));
        cyc("ra_ex", 0, RT, 0, 0, 0, 1, mk(0,0,0,0,0,2,0,0,0,0,0,0));
        cyc("ra_wb", 0, RT, 0, 0, 0, 1, mk(0,0,0,0,0,0,0,1,0,0,1,0));
        // R slt
        cyc("rl_f",  0, RT, 2, 0, 0, 1, mk(1,0,0,1,2,0,2,0,0,0,0,0));
        cyc("rl_d",  0, RT, 2, 0, 0, 1, mk(0,0,0,0,0,1,1,0,0,0,0,0));
        cyc("rl_ex", 0, RT, 2, 0, 0, 1, mk(0,0,0,0,0,2,0,0,0,5,0,0));
        cyc("rl_wb", 0, RT, 2, 0, 0, 1, mk(0,0,0,0,0,0,0,1,0,0,1,0));
        // addi with funct7b5=1 must still add (op[5]=0)
        cyc("ia_f",  0, IT, 0, 1, 0, 1, mk(1,0,0,1,2,0,2,0,0,0,0,0));
        cyc("ia_d",  0, IT, 0, 1, 0, 1, mk(0,0,0,0,0,1,1,0,0,0,0,0));
        cyc("ia_ex", 0, IT, 0, 1, 0, 1, mk(0,0,0,0,0,2,1,0,0,0,0,0));
        cyc("ia_wb", 0, IT, 0, 1, 0, 1, mk(0,0,0,0,0,0,0,1,0,0,1,0));
        // ori, andi
        cyc("io_f",  0, IT, 6, 0, 0, 1, mk(1,0,0,1,2,0,2,0,0,0,0,0));
        cyc("io_d",  0, IT, 6, 0, 0, 1, mk(0,0,0,0,0,1,1,0,0,0,0,0));
        cyc("io_ex", 0, IT, 7, 0, 0, 1, mk(0,0,0,0,0,2,1,0,0,2,0,0));
        cyc("io_wb", 0, IT, 7, 0, 0, 1, mk(0,0,0,0,0,0,0,1,0,0,1,0));
        // beq taken
        cyc("bt_f", 0, BQ, 0, 0, 1, 1, mk(1,0,0,1,2,0,2,0,2,0,0,0));
        cyc("bt_d", 0, BQ, 0, 0, 1, 1, mk(0,0,0,0,0,1,1,0,2,0,0,0));
        cyc("bt_b", 0, BQ, 0, 0, 1, 1, mk(1,0,0,0,0,2,0,0,2,1,1,0));
        // beq not taken
        cyc("bn_f", 0, BQ, 0, 0, 0, 1, mk(1,0,0,1,2,0,2,0,2,0,0,0));
        cyc("bn_d", 0, BQ, 0, 0, 1, 1, mk(0,0,0,0,0,1,1,0,2,0,0,0));
        cyc("bn_b", 0, BQ, 0, 0, 0, 1, mk(0,0,0,0,0,2,0,0,2,1,1,0));
        // jal
        cyc("j_f",  0, JL, 0, 0, 0, 1, mk(1,0,0,1,2,0,2,0,3,0,0,0));
        cyc("j_d",  0, JL, 0, 0, 0, 1, mk(0,0,0,0,0,1,1,0,3,0,0,0));
        cyc("j_j",  0, JL, 0, 0, 0, 0, mk(1,0,0,0,0,1,2,0,3,0,0,0));
        cyc("j_wb", 0, JL, 0, 0, 0, 0, mk(0,0,0,0,0,0,0,1,3,0,1,0));
        // lw with one MEMREAD stall
        cyc("ls_f",  0, LW, 0, 0, 0, 1, mk(1,0,0,1,2,0,2,0,0,0,0,0));
        cyc("ls_d",  0, LW, 0, 0, 0, 1, mk(0,0,0,0,0,1,1,0,0,0,0,0));
        cyc("ls_ma", 0, LW, 0, 0, 0, 1, mk(0,0,0,0,0,2,1,0,0,0,0,0));
        cyc("ls_m0", 0, LW, 0, 0, 0, 0, mk(0,1,0,0,0,0,0,0,0,0,0,0));
        cyc("ls_m1", 0, LW, 0, 0, 0, 1, mk(0,1,0,0,0,0,0,0,0,0,0,0));
        cyc("ls_wb", 0, LW, 0, 0, 0, 1, mk(0,0,0,0,1,0,0,1,0,0,1,0));
        // illegal opcode
        cyc("il_f", 0, BAD, 0, 0, 0, 1, mk(1,0,0,1,2,0,2,0,0,0,0,0));
        cyc("il_d", 0, BAD, 0, 0, 0, 1, mk(0,0,0,0,0,1,1,0,0,0,1,1));
        cyc("il_n", 0, BAD, 0, 0, 0, 0, mk(0,0,0,0,2,0,2,0,0,0,0,0));
        // reset while in MEMWRITE
        cyc("rw_f",  0, SW, 0, 0, 0, 1, mk(1,0,0,1,2,0,2,0,1,0,0,0));
        cyc("rw_d",  0, SW, 0, 0, 0, 1, mk(0,0,0,0,0,1,1,0,1,0,0,0));
        cyc("rw_ma", 0, SW, 0, 0, 0, 1, mk(0,0,0,0,0,2,1,0,1,0,0,0));
        cyc("rw_mw", 1, SW, 0, 0, 0, 1, mk(0,1,0,0,0,0,0,0,1,0,0,0));
        cyc("rw_f2", 0, SW, 0, 0, 0, 0, mk(0,0,0,0,2,0,2,0,1,0,0,0));
        cyc("rw_f3", 0, SW, 0, 0, 0, 1, mk(1,0,0,1,2,0,2,0,1,0,0,0));
        cyc("rw_d2", 0, SW, 0, 0, 0, 1, mk(0,0,0,0,0,1,1,0,1,0,0,0));
        for (int i = 0; i < 4 && q.size() > 0; i++) @(posedge clk);
        if (q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: got %0d pending required 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
